axil_ram_slave: RTL and testbench

AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

---
 rtl/axil_ram_pkg.sv | 22 ++
 rtl/dpram_be.sv | 49 ++++
 rtl/axil_ram_slave.sv | 212 +++++++++++++++++++++
 tb/tb_axil_ram_slave.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ram_pkg.sv
// axil_ram_pkg: AXI response codes and the FSM state encodings
// shared by the AXI-Lite RAM slave.
package axil_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/dpram_be.sv
// dpram_be: byte-enable, read-first RAM. Side A has its own read and
// write address so an AXI read and commit can share a cycle; side B is native.
module dpram_be #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 1024,
    parameter int WA_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_ren,
    input  logic [WA_W-1:0]       a_raddr,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic [DATA_W/8-1:0]   a_we,
    input  logic [WA_W-1:0]       a_waddr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic                  b_en,
    input  logic [DATA_W/8-1:0]   b_we,
    input  logic [WA_W-1:0]       b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [WORDS];

    // Contents are never reset; one block owns every write to the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (a_we[i])
                mem[a_waddr][8*i +: 8] <= a_wdata[8*i +: 8];
            if (b_en && b_we[i])
                mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_ren)
                a_rdata <= mem[a_raddr];
            if (b_en)
                b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/axil_ram_slave.sv
// axil_ram_slave: AXI4-Lite slave over a byte-enable RAM with a native
// second port, independent read/write FSMs and transaction counters.
module axil_ram_slave
    import axil_ram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 273280,
    localparam int STRB_W   = DATA_W / 8,
    localparam int LSB      = $clog2(STRB_W),
    localparam int WORDS    = MEM_BYTES / STRB_W,
    localparam int WA_W     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DATA_W-1:0] axi_wdata,
    input  logic [STRB_W-1:0] axi_wstrb,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [DATA_W-1:0] axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    input  logic              ram_b_en,
    input  logic [STRB_W-1:0] ram_b_we,
    input  logic [WA_W-1:0]   ram_b_addr,
    input  logic [DATA_W-1:0] ram_b_wdata,
    output logic [DATA_W-1:0] ram_b_rdata,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       rd_cnt
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic              aw_rdy, w_rdy, b_vld, commit;
    logic              ar_rdy, r_vld, r_ren;
    logic [WA_W-1:0]   aw_idx_q, ar_idx_q;
    logic              aw_err_q, ar_err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [STRB_W-1:0] ram_a_we;
    logic [DATA_W-1:0] ram_a_rdata;
    logic              collide;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Readies are masked by rst so nothing is offered while reset is held.
    assign axi_awready = aw_rdy & ~rst;
    assign axi_wready  = w_rdy & ~rst;
    assign axi_arready = ar_rdy & ~rst;
    assign axi_bvalid  = b_vld;
    assign axi_rvalid  = r_vld;

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid & axi_wready;
    assign b_hs  = axi_bvalid & axi_bready;
    assign ar_hs = axi_arvalid & axi_arready;
    assign r_hs  = axi_rvalid & axi_rready;

    assign collide = ram_b_en && (|ram_b_we) && (ram_b_addr == aw_idx_q);

    assign axi_bresp = (w_state == W_RESP && aw_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rresp = (r_state == R_DATA && ar_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_rdata = (r_state == R_DATA && !ar_err_q) ? ram_a_rdata : '0;

    assign ram_a_we = (commit && !aw_err_q) ? wstrb_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state  <= W_IDLE;
            aw_idx_q <= '0;
            aw_err_q <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_idx_q <= axi_awaddr[LSB+WA_W-1:LSB];
                aw_err_q <= {1'b0, axi_awaddr} >= LIMIT;
            end
            if (w_hs) begin
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
        end
    end

    always_comb begin
        w_next = w_state;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        b_vld  = 1'b0;
        commit = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (axi_awvalid && axi_wvalid)
                    w_next = W_COMMIT;
                else if (axi_awvalid)
                    w_next = W_HAVE_AW;
                else if (axi_wvalid)
                    w_next = W_HAVE_W;
            end
            W_HAVE_AW: begin
                w_rdy = 1'b1;
                if (axi_wvalid)
                    w_next = W_COMMIT;
            end
            W_HAVE_W: begin
                aw_rdy = 1'b1;
                if (axi_awvalid)
                    w_next = W_COMMIT;
            end
            // Hold off while port B writes the same word so B lands first.
            W_COMMIT: begin
                if (!collide) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (axi_bready)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= R_IDLE;
            ar_idx_q <= '0;
            ar_err_q <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                ar_idx_q <= axi_araddr[LSB+WA_W-1:LSB];
                ar_err_q <= {1'b0, axi_araddr} >= LIMIT;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        r_ren  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                ar_rdy = 1'b1;
                if (axi_arvalid)
                    r_next = R_WAIT;
            end
            R_WAIT: begin
                r_ren  = !ar_err_q;
                r_next = R_DATA;
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (axi_rready)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (b_hs)
                wr_cnt <= wr_cnt + 32'd1;
            if (r_hs)
                rd_cnt <= rd_cnt + 32'd1;
        end
    end

    dpram_be #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .WA_W   (WA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_ren   (r_ren),
        .a_raddr (ar_idx_q),
        .a_rdata (ram_a_rdata),
        .a_we    (ram_a_we),
        .a_waddr (aw_idx_q),
        .a_wdata (wdata_q),
        .b_en    (ram_b_en),
        .b_we    (ram_b_we),
        .b_addr  (ram_b_addr),
        .b_wdata (ram_b_wdata),
        .b_rdata (ram_b_rdata)
    );

endmodule

// File: tb/tb_axil_ram_slave.sv
// tb_axil_ram_slave: directed and randomized AXI-Lite / port-B traffic
// checked against a word-array memory model kept in the bench.
module tb_axil_ram_slave;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 273280;
    localparam int WA_W      = 17;
    localparam int LAST_W    = MEM_BYTES / 4 - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [ADDR_W-1:0] araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic              ram_b_en = 1'b0;
    logic [3:0]        ram_b_we = '0;
    logic [WA_W-1:0]   ram_b_addr = '0;
    logic [DATA_W-1:0] ram_b_wdata = '0;
    logic [DATA_W-1:0] ram_b_rdata;
    logic [31:0]       wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    axil_ram_slave #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awaddr  (awaddr),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .axi_araddr  (araddr),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready),
        .ram_b_en    (ram_b_en),
        .ram_b_we    (ram_b_we),
        .ram_b_addr  (ram_b_addr),
        .ram_b_wdata (ram_b_wdata),
        .ram_b_rdata (ram_b_rdata),
        .wr_cnt      (wr_cnt),
        .rd_cnt      (rd_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    logic [31:0] mdl [int];

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void mdl_write(input logic [31:0] addr,
                                      input logic [31:0] data,
                                      input logic [3:0] strb);
        int w;
        logic [31:0] t;
        if (addr >= MEM_BYTES) return;
        w = int'(addr / 4);
        t = mdl.exists(w) ? mdl[w] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (strb[i]) t[8*i +: 8] = data[8*i +: 8];
        mdl[w] = t;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        int w;
        if (addr >= MEM_BYTES) return 32'h0;
        w = int'(addr / 4);
        return mdl.exists(w) ? mdl[w] : 32'h0;
    endfunction

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 63);
        if (r < 3)
            return MEM_BYTES + $urandom_range(0, 4096);
        if (r == 3)
            return 32'hFFFF_FFFC;
        if (r < 9)
            return (MEM_BYTES - 16) + $urandom_range(0, 15);
        return $urandom_range(0, 255);
    endfunction

    task automatic pb_write(input int w, input logic [31:0] d,
                            input logic [3:0] we);
        ram_b_en    = 1'b1;
        ram_b_we    = we;
        ram_b_addr  = WA_W'(w);
        ram_b_wdata = d;
        @(posedge clk); #1;
        ram_b_en = 1'b0;
        ram_b_we = '0;
        mdl_write(32'(w * 4), d, we);
    endtask

    task automatic pb_check(input int w);
        logic [31:0] d;
        ram_b_en   = 1'b1;
        ram_b_we   = '0;
        ram_b_addr = WA_W'(w);
        @(posedge clk); #1;
        ram_b_en = 1'b0;
        d = ram_b_rdata;
        expect_eq("pb_rdata", d, mdl_read(32'(w * 4)));
        @(posedge clk); #1;
        expect_eq("pb_rdata_hold", ram_b_rdata, d);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int order,
                             output logic [1:0] resp, output int lat);
        logic aw_todo, w_todo, hs_aw, hs_w, seen;
        int n;
        aw_todo = 1'b1;
        w_todo  = 1'b1;
        n = 0;
        if (order != 1) begin awaddr = addr; awvalid = 1'b1; end
        if (order != 0) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
        while ((aw_todo || w_todo) && n < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            n++;
            if (hs_aw) begin awvalid = 1'b0; aw_todo = 1'b0; end
            if (hs_w) begin wvalid = 1'b0; w_todo = 1'b0; end
            if (!aw_todo && w_todo && !wvalid) begin
                wdata = data; wstrb = strb; wvalid = 1'b1;
            end
            if (!w_todo && aw_todo && !awvalid) begin
                awaddr = addr; awvalid = 1'b1;
            end
        end
        expect_eq("aw_w_accepted", {aw_todo, w_todo}, 2'b00);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 1;
        while (!bvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        seen = bvalid;
        resp = bresp;
        expect_eq("bvalid_seen", seen, 1'b1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        if (seen) exp_wr++;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int n;
        logic seen;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        seen = rvalid;
        d    = rdata;
        resp = rresp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            expect_eq("r_hold_valid", rvalid, 1'b1);
            expect_eq("r_hold_data", rdata, d);
            expect_eq("r_hold_resp", rresp, resp);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        if (seen) exp_rd++;
        expect_eq("r_done", rvalid, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order);
        logic [1:0] resp;
        int lat;
        axi_write(addr, data, strb, order, resp, lat);
        expect_eq("bresp", resp, (addr >= MEM_BYTES) ? 2'b10 : 2'b00);
        expect_eq("b_latency", lat, 2);
        mdl_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] d);
        logic [1:0] resp;
        logic [31:0] e;
        int lat;
        e = mdl_read(addr);
        axi_read(addr, hold, d, resp, lat);
        expect_eq("rresp", resp, (addr >= MEM_BYTES) ? 2'b10 : 2'b00);
        expect_eq("rdata", d, e);
        expect_eq("r_latency", lat, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, w0;
        int k, w;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_awready", awready, 1'b0);
        expect_eq("rst_wready", wready, 1'b0);
        expect_eq("rst_arready", arready, 1'b0);
        expect_eq("rst_bvalid", bvalid, 1'b0);
        expect_eq("rst_rvalid", rvalid, 1'b0);
        expect_eq("rst_resps", {bresp, rresp}, 4'h0);
        expect_eq("rst_rdata", rdata, 32'h0);
        expect_eq("rst_b_rdata", ram_b_rdata, 32'h0);
        expect_eq("rst_cnts", {wr_cnt, rd_cnt}, 64'h0);
        rst = 1'b0;
        #1;
        expect_eq("rel_readies", {awready, wready, arready}, 3'b111);

        // known contents through port B
        for (int i = 0; i < 64; i++)
            pb_write(i, $urandom, 4'hF);
        for (int i = LAST_W - 3; i <= LAST_W; i++)
            pb_write(i, $urandom, 4'hF);

        // AW before W, then readback
        do_write(32'h10, 32'hA5A5_1234, 4'hF, 0);
        do_read(32'h10, 0, d);
        expect_eq("t1_data", d, 32'hA5A5_1234);

        // W before AW, partial strobe
        do_write(32'h20, 32'hFFFF_FFFF, 4'hF, 1);
        do_write(32'h20, 32'h0000_0000, 4'b0101, 1);
        do_read(32'h20, 0, d);
        expect_eq("t2_data", d, 32'hFF00_FF00);

        // out of range write/read leaves word 0 alone
        w0 = mdl_read(32'h0);
        do_write(MEM_BYTES, 32'hDEAD_BEEF, 4'hF, 2);
        do_read(MEM_BYTES, 0, d);
        expect_eq("t3_oor_rdata", d, 32'h0);
        do_read(32'h0, 0, d);
        expect_eq("t3_word0", d, w0);

        // zero strobe and last valid word
        do_write(32'h30, 32'h1234_5678, 4'h0, 2);
        do_read(32'h30, 0, d);
        do_write(32'(LAST_W * 4 + 3), 32'h0BAD_F00D, 4'hF, 0);
        do_read(32'(LAST_W * 4), 0, d);
        expect_eq("last_word", d, 32'h0BAD_F00D);

        // rready held low
        do_read(32'h10, 5, d);

        // port B write collides with AXI commit to word 4
        awaddr  = 32'h10;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata   = 32'h2222_2222;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        k = 1;
        ram_b_en    = 1'b1;
        ram_b_we    = 4'hF;
        ram_b_addr  = WA_W'(4);
        ram_b_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        ram_b_en = 1'b0;
        ram_b_we = '0;
        k++;
        while (!bvalid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        expect_eq("coll_b_latency", k, 3);
        expect_eq("coll_bresp", bresp, 2'b00);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        if (k < 50) exp_wr++;
        mdl_write(32'h10, 32'h2222_2222, 4'hF);
        do_read(32'h10, 0, d);
        expect_eq("coll_final", d, 32'h2222_2222);
        pb_check(4);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            a  = pick_addr();
            if (op < 4) begin
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2));
            end else if (op < 8) begin
                do_read(a, $urandom_range(0, 2), d);
            end else begin
                w = (a < MEM_BYTES) ? int'(a / 4) : $urandom_range(0, 63);
                if (op == 8) pb_write(w, $urandom, 4'($urandom));
                else pb_check(w);
            end
        end
        expect_eq("wr_cnt", wr_cnt, 32'(exp_wr));
        expect_eq("rd_cnt", rd_cnt, 32'(exp_rd));

        // reset while a write is half accepted
        awaddr  = 32'h44;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata   = 32'hDEAD_BEEF;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        wvalid = 1'b0;
        expect_eq("mid_rst_readies", {awready, wready, arready}, 3'b000);
        expect_eq("mid_rst_valids", {bvalid, rvalid}, 2'b00);
        expect_eq("mid_rst_b_rdata", ram_b_rdata, 32'h0);
        expect_eq("mid_rst_cnts", {wr_cnt, rd_cnt}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        expect_eq("post_rst_readies", {awready, wready, arready}, 3'b111);
        exp_wr = 0;
        exp_rd = 0;
        do_write(32'h40, 32'hCAFE_0040, 4'hF, 2);
        do_read(32'h40, 0, d);
        expect_eq("post_rst_data", d, 32'hCAFE_0040);
        do_read(32'h44, 0, d);
        expect_eq("post_rst_wr_cnt", wr_cnt, 32'd1);
        expect_eq("post_rst_rd_cnt", rd_cnt, 32'(exp_rd));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
